// File: rtl/cis_frame_capture.sv
// cis_frame_capture: CIS parallel camera bus into the SRAM frame buffer.
// Syncs the camera bus into clk, packs RGB444 pixels and writes y*H+x.
module cis_frame_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_active,
    output logic              frame_done,
    output logic              line_err,
    output logic [8:0]        o_x_count,
    output logic [7:0]        o_y_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE
    } state_t;

    localparam logic [8:0]        H_X    = 9'(H_ACTIVE);
    localparam logic [7:0]        V_Y    = 8'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    // index 0 = s1, 1 = s2, 2 = s3 (edge-detect tap)
    logic [2:0] pclk_q, vsync_q, href_q;
    logic [7:0] data1_q, data2_q;

    state_t            state_q, state_d;
    logic [8:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        y_inc;
    logic              phase_q, phase_d;
    logic [3:0]        r_q, r_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              pend_q, pend_d;

    logic pclk_rise, vs_rise, vs_fall, href_s2, href_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_q  <= '0;
            vsync_q <= '0;
            href_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            pclk_q  <= {pclk_q[1:0], cam_pclk};
            vsync_q <= {vsync_q[1:0], cam_vsync};
            href_q  <= {href_q[1:0], cam_href};
            data1_q <= cam_data;
            data2_q <= data1_q;
        end
    end

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vs_rise   = vsync_q[1] & ~vsync_q[2];
    assign vs_fall   = ~vsync_q[1] & vsync_q[2];
    assign href_s2   = href_q[1];
    assign href_fall = ~href_q[1] & href_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            phase_q   <= 1'b0;
            r_q       <= '0;
            addr_q    <= '0;
            base_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            phase_q   <= phase_d;
            r_q       <= r_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        y_inc     = '0;
        phase_d   = phase_q;
        r_d       = r_q;
        addr_d    = addr_q;
        base_d    = base_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pend_d    = 1'b0;
        done_d    = pend_q;

        unique case (state_q)
            IDLE: begin
                if (capture_en) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    base_d  = '0;
                end
            end
            CAPTURE: begin
                if (pclk_rise && href_s2) begin
                    if (!phase_q) begin
                        r_d     = data2_q[3:0];
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < H_X && y_q < V_Y) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {r_q, data2_q};
                            addr_d    = addr_q + 1'b1;
                        end
                        if (x_q != 9'h1FF) x_d = x_q + 9'd1;
                    end
                end else if (!href_s2) begin
                    phase_d = 1'b0;
                end

                if (href_fall) begin
                    if (x_q != H_X) err_d = 1'b1;
                    x_d = '0;
                    if (x_q != '0) begin
                        y_inc = (y_q == 8'hFF) ? y_q : y_q + 8'd1;
                        y_d   = y_inc;
                        if (y_inc < V_Y) begin
                            base_d = base_q + H_STEP;
                            addr_d = base_q + H_STEP;
                        end
                    end
                end

                // a write issued alongside the frame end lands one clk before frame_done
                if (vs_rise) begin
                    state_d = capture_en ? WAIT_SOF : IDLE;
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (wr_en_d) pend_d = 1'b1;
                    else         done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_active = (state_q == CAPTURE);
    assign frame_done   = done_q;
    assign line_err     = err_q;
    assign o_x_count    = x_q;
    assign o_y_count    = y_q;

endmodule
